// File: rtl/vending_pkg.sv
// Shared definitions for the parametrised vending controller.
package vending_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CREDIT   = 2'd1;
  localparam logic [1:0] ST_DISPENSE = 2'd2;
  localparam logic [1:0] ST_CHANGE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE     = ST_IDLE,
    CREDIT   = ST_CREDIT,
    DISPENSE = ST_DISPENSE,
    CHANGE   = ST_CHANGE
  } state_t;

  localparam int COIN5  = 5;
  localparam int COIN10 = 10;

  // Price vectors are zero-extended to this width before slicing, so one
  // helper serves every N_PROD / CREDIT_W combination.
  localparam int PRICE_VEC_W = 256;

  // Returns slice idx (width w) of a packed price vector.
  function automatic int price_slice(input logic [PRICE_VEC_W-1:0] prices,
                                     input int idx, input int w);
    logic [PRICE_VEC_W-1:0] shifted;
    shifted = prices >> (idx * w);
    return int'(shifted[31:0]) & ((1 << w) - 1);
  endfunction

endpackage

// File: rtl/vending_change_unit.sv
// Change payout: holds the credit being returned and emits one 10 or 5
// coin pulse per enabled cycle until it is exhausted.
module vending_change_unit
  import vending_pkg::*;
#(
  parameter int CREDIT_W = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [CREDIT_W-1:0] load_value,
  input  logic                enable,
  output logic [CREDIT_W-1:0] remaining,
  output logic                done,
  output logic                change5,
  output logic                change10
);

  localparam logic [CREDIT_W-1:0] TEN  = CREDIT_W'(COIN10);
  localparam logic [CREDIT_W-1:0] FIVE = CREDIT_W'(COIN5);

  // High when the pulse issued this cycle empties the credit, so the
  // controller can leave CHANGE on the same edge as the last pulse.
  assign done = (remaining <= TEN);

  // Load on entry, then pay out largest coin first.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      change5   <= 1'b0;
      change10  <= 1'b0;
    end else begin
      change5  <= 1'b0;
      change10 <= 1'b0;
      if (load) begin
        remaining <= load_value;
      end else if (enable && (remaining != '0)) begin
        if (remaining >= TEN) begin
          remaining <= remaining - TEN;
          change10  <= 1'b1;
        end else begin
          remaining <= (remaining >= FIVE) ? (remaining - FIVE) : '0;
          change5   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/vending_fsm_param.sv
// Multi-product vending controller: coin accumulation, selection
// arbitration, price lookup and hand-off to the change unit.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   IDLE     | no credit held
//   CREDIT   | credit held, waiting for coins/selection/cancel
//   DISPENSE | product released this cycle (one cycle only)
//   CHANGE   | returning remaining credit as 10/5 pulses
module vending_fsm_param
  import vending_pkg::*;
#(
  parameter int                         N_PROD     = 4,
  parameter int                         CREDIT_W   = 7,
  parameter int                         MAX_CREDIT = 50,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES     = {7'd20, 7'd15, 7'd10, 7'd5},
  localparam int                        ID_W       = $clog2(N_PROD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                credit5,
  input  logic                credit10,
  input  logic                cancel,
  input  logic                sel_valid,
  input  logic [ID_W-1:0]     sel_id,
  output logic [CREDIT_W-1:0] credit,
  output logic [1:0]          current_state,
  output logic                busy,
  output logic                dispense,
  output logic [ID_W-1:0]     dispense_id,
  output logic                change5,
  output logic                change10,
  output logic                coin_reject,
  output logic                sel_err
);

  localparam logic [PRICE_VEC_W-1:0] PRICES_EXT = PRICE_VEC_W'(PRICES);
  localparam logic [CREDIT_W:0]      C5_W       = (CREDIT_W+1)'(COIN5);
  localparam logic [CREDIT_W:0]      C10_W      = (CREDIT_W+1)'(COIN10);
  localparam logic [CREDIT_W:0]      MAX_W      = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                busy_d, dispense_d, coin_reject_d, sel_err_d;
  logic [ID_W-1:0]     dispense_id_d;

  logic [CREDIT_W:0]   coin_val, coin_sum;
  logic                coin_evt, coin_fits, sel_ok, take_coin;
  logic [CREDIT_W-1:0] price;

  logic                chg_load, chg_en, chg_done;
  logic [CREDIT_W-1:0] chg_load_value, chg_remaining;

  vending_change_unit #(.CREDIT_W(CREDIT_W)) u_change (
    .clk        (clk),
    .rst        (rst),
    .load       (chg_load),
    .load_value (chg_load_value),
    .enable     (chg_en),
    .remaining  (chg_remaining),
    .done       (chg_done),
    .change5    (change5),
    .change10   (change10)
  );

  // Coin value and ceiling check; one extra bit keeps the sum from wrapping.
  always_comb begin
    coin_val = '0;
    if (credit5)  coin_val = coin_val + C5_W;
    if (credit10) coin_val = coin_val + C10_W;
    coin_evt  = credit5 | credit10;
    coin_sum  = {1'b0, credit_q} + coin_val;
    coin_fits = (coin_sum <= MAX_W);
  end

  // Price lookup; a selection is valid only against the registered credit.
  assign price  = CREDIT_W'(price_slice(PRICES_EXT, int'(sel_id), CREDIT_W));
  assign sel_ok = (int'(sel_id) < N_PROD) && (credit_q >= price);

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    dispense_d     = 1'b0;
    dispense_id_d  = '0;
    coin_reject_d  = 1'b0;
    sel_err_d      = 1'b0;
    take_coin      = 1'b0;
    chg_load       = 1'b0;
    chg_load_value = credit_q;
    chg_en         = 1'b0;

    case (state_q)
      IDLE, CREDIT: begin
        if (cancel && (state_q == CREDIT)) begin
          state_d       = CHANGE;
          chg_load      = 1'b1;
          credit_d      = '0;
          coin_reject_d = coin_evt;
        end else if (sel_valid && sel_ok) begin
          state_d       = DISPENSE;
          dispense_d    = 1'b1;
          dispense_id_d = sel_id;
          credit_d      = credit_q - price;
          coin_reject_d = coin_evt;
        end else begin
          sel_err_d = sel_valid;
          take_coin = coin_evt;
        end
        if (take_coin) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_evt;
        sel_err_d     = sel_valid;
        if (credit_q != '0) begin
          state_d  = CHANGE;
          chg_load = 1'b1;
          credit_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_evt;
        sel_err_d     = sel_valid;
        chg_en        = 1'b1;
        if (chg_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DISPENSE) || (state_d == CHANGE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      credit_q    <= '0;
      busy        <= 1'b0;
      dispense    <= 1'b0;
      dispense_id <= '0;
      coin_reject <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      credit_q    <= credit_d;
      busy        <= busy_d;
      dispense    <= dispense_d;
      dispense_id <= dispense_id_d;
      coin_reject <= coin_reject_d;
      sel_err     <= sel_err_d;
    end
  end

  // While paying out, the change unit holds the live credit.
  assign credit        = (state_q == CHANGE) ? chg_remaining : credit_q;
  assign current_state = state_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Bench for vending_fsm_param: directed vector table plus random traffic
// against a queue-based reference model.
module tb_vending_fsm_param;

  logic       clk = 1'b0;
  logic       rst, credit5, credit10, cancel, sel_valid;
  logic [1:0] sel_id;
  logic [6:0] credit;
  logic [1:0] current_state;
  logic       busy, dispense, change5, change10, coin_reject, sel_err;
  logic [1:0] dispense_id;

  int errors = 0;
  int checks = 0;

  vending_fsm_param #(
    .N_PROD(4), .CREDIT_W(7), .MAX_CREDIT(50),
    .PRICES({7'd20, 7'd15, 7'd10, 7'd5})
  ) dut (
    .clk(clk), .rst(rst), .credit5(credit5), .credit10(credit10),
    .cancel(cancel), .sel_valid(sel_valid), .sel_id(sel_id),
    .credit(credit), .current_state(current_state), .busy(busy),
    .dispense(dispense), .dispense_id(dispense_id), .change5(change5),
    .change10(change10), .coin_reject(coin_reject), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  // Reference model: credit plus a queue of change coins still owed.
  int m_credit, m_state;
  int m_queue[$];
  bit m_disp, m_c5, m_c10, m_rej, m_err;
  int m_id;
  int price_tab[4] = '{5, 10, 15, 20};

  function automatic void refund_into_queue(input int amount);
    m_queue.delete();
    for (int k = 0; k < amount / 10; k++) m_queue.push_back(10);
    if (amount % 10 != 0) m_queue.push_back(5);
  endfunction

  task automatic model_step(input bit r, c5, c10, can, sv, input int sid);
    int coin, v;
    m_disp = 0; m_c5 = 0; m_c10 = 0; m_rej = 0; m_err = 0; m_id = 0;
    coin = (c5 ? 5 : 0) + (c10 ? 10 : 0);
    if (r) begin
      m_credit = 0; m_state = 0; m_queue.delete();
      return;
    end
    if (m_state == 0 || m_state == 1) begin
      if (can && m_state == 1) begin
        refund_into_queue(m_credit);
        m_state = 3;
        m_rej = (coin > 0);
      end else if (sv && sid < 4 && m_credit >= price_tab[sid]) begin
        m_credit -= price_tab[sid];
        m_state = 2; m_disp = 1; m_id = sid;
        m_rej = (coin > 0);
      end else begin
        m_err = sv;
        if (coin > 0) begin
          if (m_credit + coin <= 50) begin m_credit += coin; m_state = 1; end
          else m_rej = 1;
        end
      end
    end else if (m_state == 2) begin
      m_rej = (coin > 0); m_err = sv;
      if (m_credit > 0) begin refund_into_queue(m_credit); m_state = 3; end
      else m_state = 0;
    end else begin
      m_rej = (coin > 0); m_err = sv;
      v = m_queue.pop_front();
      if (v == 10) m_c10 = 1; else m_c5 = 1;
      m_credit -= v;
      if (m_queue.size() == 0) m_state = 0;
    end
  endtask

  function automatic logic [16:0] dut_vec();
    return {credit, current_state, busy, dispense, dispense_id,
            change5, change10, coin_reject, sel_err};
  endfunction

  function automatic logic [16:0] model_vec();
    return {7'(m_credit), 2'(m_state), (m_state >= 2), m_disp, 2'(m_id),
            m_c5, m_c10, m_rej, m_err};
  endfunction

  task automatic check(input string name, input int idx, input logic [16:0] want);
    logic [16:0] got;
    got = dut_vec();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s[%0d] got{cr,st,bz,d,id,c5,c10,rej,err}=%h required=%h (got cr=%0d st=%0d, required cr=%0d st=%0d)",
               name, idx, got, want, got[16:10], got[9:8], want[16:10], want[9:8]);
    end
  endtask

  // One clock: drive inputs, advance model, sample #1 after the edge.
  task automatic step(input bit r, c5, c10, can, sv, input logic [1:0] sid, input int idx);
    rst = r; credit5 = c5; credit10 = c10; cancel = can; sel_valid = sv; sel_id = sid;
    @(posedge clk);
    model_step(r, c5, c10, can, sv, int'(sid));
    #1;
    check("model", idx, model_vec());
  endtask

  typedef struct {
    bit r, c5, c10, can, sv;
    logic [1:0] sid;
    logic [6:0] cr;
    logic [1:0] st;
    bit bz, d;
    logic [1:0] id;
    bit o5, o10, rej, err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input bit r, c5, c10, can, sv, input int sid,
                     input int cr, st, input bit bz, d, input int id,
                     input bit o5, o10, rej, err);
    vec_t v;
    v.r = r; v.c5 = c5; v.c10 = c10; v.can = can; v.sv = sv; v.sid = 2'(sid);
    v.cr = 7'(cr); v.st = 2'(st); v.bz = bz; v.d = d; v.id = 2'(id);
    v.o5 = o5; v.o10 = o10; v.rej = rej; v.err = err;
    vq.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //   r c5 c10 can sv sid | cr st bz d id o5 o10 rej err
    add(1,0,0,0,0,0,  0,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0,  5,1,0,0,0, 0,0,0,0);
    add(0,0,1,0,0,0, 15,1,0,0,0, 0,0,0,0);
    add(0,0,0,0,1,2,  0,2,1,1,2, 0,0,0,0);  // exact price
    add(0,0,0,0,0,0,  0,0,0,0,0, 0,0,0,0);
    add(0,0,0,0,0,0,  0,0,0,0,0, 0,0,0,0);
    for (int k = 1; k <= 5; k++) add(0,0,1,0,0,0, 10*k,1,0,0,0, 0,0,0,0);
    add(0,0,0,0,1,0, 45,2,1,1,0, 0,0,0,0);
    add(0,0,0,0,0,0, 45,3,1,0,0, 0,0,0,0);
    add(0,0,0,0,0,0, 35,3,1,0,0, 0,1,0,0);
    add(0,0,0,0,0,0, 25,3,1,0,0, 0,1,0,0);
    add(0,0,0,0,0,0, 15,3,1,0,0, 0,1,0,0);
    add(0,0,0,0,0,0,  5,3,1,0,0, 0,1,0,0);
    add(0,0,0,0,0,0,  0,0,0,0,0, 1,0,0,0);
    add(0,0,1,0,0,0, 10,1,0,0,0, 0,0,0,0);
    add(0,0,0,0,1,3, 10,1,0,0,0, 0,0,0,1);  // underfunded
    add(0,1,0,0,1,0,  5,2,1,1,0, 0,0,1,0);  // sel beats coin
    add(0,0,0,0,0,0,  5,3,1,0,0, 0,0,0,0);
    add(0,0,0,0,0,0,  0,0,0,0,0, 1,0,0,0);
    add(0,0,0,1,0,0,  0,0,0,0,0, 0,0,0,0);  // cancel in IDLE
    for (int k = 1; k <= 4; k++) add(0,0,1,0,0,0, 10*k,1,0,0,0, 0,0,0,0);
    add(0,1,1,0,0,0, 40,1,0,0,0, 0,0,1,0);  // 15 would exceed ceiling
    add(0,1,0,0,0,0, 45,1,0,0,0, 0,0,0,0);
    add(0,0,1,0,0,0, 45,1,0,0,0, 0,0,1,0);
    add(0,1,0,0,0,0, 50,1,0,0,0, 0,0,0,0);  // exactly at ceiling
    add(0,0,0,0,1,3, 30,2,1,1,3, 0,0,0,0);
    add(0,1,0,1,1,1, 30,3,1,0,0, 0,0,1,1);  // busy: reject/err, no cancel
    add(0,0,1,0,0,0, 20,3,1,0,0, 0,1,1,0);
    add(0,0,0,0,0,0, 10,3,1,0,0, 0,1,0,0);
    add(0,0,0,0,0,0,  0,0,0,0,0, 0,1,0,0);
    add(0,0,1,0,0,0, 10,1,0,0,0, 0,0,0,0);
    add(0,0,1,0,0,0, 20,1,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 25,1,0,0,0, 0,0,0,0);
    add(0,1,0,1,1,0, 25,3,1,0,0, 0,0,1,0);  // cancel beats sel and coin
    add(0,0,0,0,0,0, 15,3,1,0,0, 0,1,0,0);
    add(0,0,0,0,0,0,  5,3,1,0,0, 0,1,0,0);
    add(1,0,0,0,0,0,  0,0,0,0,0, 0,0,0,0);  // reset mid-payout
    add(0,0,0,0,0,0,  0,0,0,0,0, 0,0,0,0);

    m_credit = 0; m_state = 0;
    rst = 1'b1; credit5 = 1'b0; credit10 = 1'b0; cancel = 1'b0;
    sel_valid = 1'b0; sel_id = 2'd0;

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      step(v.r, v.c5, v.c10, v.can, v.sv, v.sid, i);
      check("vec", i, {v.cr, v.st, v.bz, v.d, v.id, v.o5, v.o10, v.rej, v.err});
    end

    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 5) == 0,
           2'($urandom_range(0, 3)),
           1000 + n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
